sprite_compositor: RTL
======================

Name: sprite_compositor

Overview:
- Parametrised, pipelined pixel compositor for the 1440x900 game display.
- Takes the current draw coordinate and N_SPR sprite descriptors, and outputs the 12-bit RGB pixel 2 cycles later.
- Sprites overlay the background by fixed priority; the background is a bordered playfield.
- Also reports, once per frame, which sprites overlapped another sprite, so game logic can detect character/food contact without its own pixel test.

Parameters:
- N_SPR, 4, number of sprite channels (1..8); channel 0 has highest priority
- SCREEN_W, 1440, visible width in pixels
- SCREEN_H, 900, visible height in pixels
- BORDER, 11, border thickness in pixels
- BORDER_RGB, 12'h0F0, border colour {r,g,b}
- BG_RGB, 12'h00B, playfield colour {r,g,b}

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous active-high reset
- pix_valid_in  in  1  draw_x/draw_y is a visible pixel this cycle
- draw_x  in  11  current pixel column
- draw_y  in  10  current pixel row
- frame_start  in  1  one-cycle pulse at the start of each frame
- spr_en  in  N_SPR  per-sprite enable
- spr_x  in  11*N_SPR  sprite left edge; channel i occupies bits [11i+10:11i]
- spr_y  in  10*N_SPR  sprite top edge
- spr_size  in  6*N_SPR  sprite side length in pixels; 0 means invisible
- spr_rgb  in  12*N_SPR  sprite colour {r,g,b}
- pix_valid_out  out  1  r/g/b holds a valid pixel
- r  out  4  red
- g  out  4  green
- b  out  4  blue
- coll_status  out  N_SPR  bit i set if sprite i overlapped any other sprite during the previous frame
- coll_valid  out  1  one-cycle pulse when coll_status updates

Behaviour:
- Reset: on rst=1 at a clk edge, clear pipeline valid bits, r/g/b, pix_valid_out, coll_status, coll_valid and the internal collision accumulator. A pixel in flight is discarded.
- Stage 1 (register at edge after input):
  - Hit test per channel i: hit[i] = spr_en[i] & (spr_size[i]!=0) & (spr_x[i] <= draw_x < spr_x[i]+spr_size[i]) & (spr_y[i] <= draw_y < spr_y[i]+spr_size[i]).
  - Sums use 12/11-bit widths, so a sprite near the right/bottom edge does not wrap to 0.
  - Border test: border = (draw_x < BORDER) | (draw_x >= SCREEN_W-BORDER) | (draw_y < BORDER) | (draw_y >= SCREEN_H-BORDER).
  - Register hit vector, border flag, the spr_rgb snapshot of hit channels, and pix_valid_in.
- Stage 2:
  - Pixel colour = spr_rgb of the lowest-index set hit bit; else BORDER_RGB if border; else BG_RGB.
  - Sprites draw over the border.
  - pix_valid_out = stage-1 valid.
  - If not valid, r/g/b = 0 (blanking).
- Latency: exactly 2 clk cycles from input to r/g/b. Throughput is one pixel per cycle with no stalls; sprite inputs are sampled in the same cycle as their pixel.
- Collision accumulator:
  - When a stage-1 pixel is valid and popcount(hit) >= 2, acc <= acc | hit.
  - Hits with pix_valid_in=0 are ignored.
- Frame boundary:
  - On a frame_start input cycle, coll_status <= acc and coll_valid <= 1 on the next edge.
  - acc restarts from the collision contribution of the stage-1 pixel at that same edge, which counts toward the new frame.
  - coll_valid is 0 in all other cycles.
  - frame_start during reset is ignored.
- Successive frame_start pulses with no pixels between them publish coll_status = 0.
- coll_status holds its value between updates.

Test Plan:
- Reset mid-stream: drive valid pixels, assert rst for 1 cycle → next cycle pix_valid_out=0, r/g/b=0; coll_status=0; first output 2 cycles after rst deasserts.
- Background/border/latency: draw (5,5) then (100,100) then (1429,500) → r/g/b = 0/F/0, 0/0/B, 0/F/0 on cycles +2, +3, +4.
- Sprite edges: spr0 x=100, y=100, size=32, rgb=F00 →
  - (100,100) red
  - (131,131) red
  - (132,100) background 00B
  - spr_size=0 or spr_en=0 → background
- Priority: spr0 red at (200,200,32), spr1 yellow FF0 at (210,210,16); draw (215,215) → red. Disable spr0 → yellow.
- Collision per frame:
  - Overlap as above over one frame, then pulse frame_start → coll_valid pulse, coll_status=2'b11 (bits 0,1).
  - Next frame with spr1 moved to (400,400) → coll_status=0.
- Wrap/simultaneity:
  - spr x=1430, size=32, draw_x=5 → no hit.
  - frame_start coinciding with an overlapping pixel → that hit appears in the following frame's coll_status, not the current one.

Source files
------------

// File: rtl/sprite_compositor_if.sv
// Pixel-stream bus of the sprite compositor: draw coordinate, sprite descriptors,
// composited pixel and per-frame collision report.
interface sprite_compositor_if #(
    parameter int N_SPR = 4
);
    // Handshake: pix_valid_in qualifies draw_x/draw_y in the same cycle and
    // pix_valid_out qualifies r/g/b. There is no ready signal, because the
    // compositor accepts one pixel every cycle and never stalls.
    logic                  pix_valid_in;
    logic [10:0]           draw_x;
    logic [9:0]            draw_y;
    logic                  frame_start;
    logic [N_SPR-1:0]      spr_en;
    logic [11*N_SPR-1:0]   spr_x;
    logic [10*N_SPR-1:0]   spr_y;
    logic [6*N_SPR-1:0]    spr_size;
    logic [12*N_SPR-1:0]   spr_rgb;
    logic                  pix_valid_out;
    logic [3:0]            r;
    logic [3:0]            g;
    logic [3:0]            b;
    logic [N_SPR-1:0]      coll_status;
    logic                  coll_valid;

    modport master (
        output pix_valid_in, draw_x, draw_y, frame_start,
        output spr_en, spr_x, spr_y, spr_size, spr_rgb,
        input  pix_valid_out, r, g, b, coll_status, coll_valid
    );

    modport slave (
        input  pix_valid_in, draw_x, draw_y, frame_start,
        input  spr_en, spr_x, spr_y, spr_size, spr_rgb,
        output pix_valid_out, r, g, b, coll_status, coll_valid
    );
endinterface

// File: rtl/sprite_compositor.sv
// Two-stage pixel compositor: fixed-priority square sprites over a bordered
// playfield, plus a per-frame sprite-overlap report.
module sprite_compositor #(
    parameter int          N_SPR      = 4,
    parameter int          SCREEN_W   = 1440,
    parameter int          SCREEN_H   = 900,
    parameter int          BORDER     = 11,
    parameter logic [11:0] BORDER_RGB = 12'h0F0,
    parameter logic [11:0] BG_RGB     = 12'h00B
) (
    input  logic clk,
    input  logic rst,
    sprite_compositor_if.slave bus
);
    localparam logic [10:0]      X_LO = 11'(BORDER);
    localparam logic [10:0]      X_HI = 11'(SCREEN_W - BORDER);
    localparam logic [9:0]       Y_LO = 10'(BORDER);
    localparam logic [9:0]       Y_HI = 10'(SCREEN_H - BORDER);
    localparam logic [N_SPR-1:0] ONE  = N_SPR'(1);

    logic [N_SPR-1:0]    hit_c;
    logic                border_c;
    logic                s1_valid;
    logic [N_SPR-1:0]    s1_hit;
    logic                s1_border;
    logic [12*N_SPR-1:0] s1_rgb;
    logic [11:0]         pix_c;
    logic [11:0]         pix_q;
    logic                valid_q;
    logic                multi_hit;
    logic [N_SPR-1:0]    contrib;
    logic [N_SPR-1:0]    acc;
    logic [N_SPR-1:0]    coll_status_q;
    logic                coll_valid_q;

    // End coordinates carry one extra bit so a sprite near the far edge cannot wrap to 0.
    for (genvar i = 0; i < N_SPR; i++) begin : g_hit
        logic [10:0] sx;
        logic [9:0]  sy;
        logic [5:0]  sz;
        logic [11:0] x_end;
        logic [10:0] y_end;
        assign sx    = bus.spr_x[11*i +: 11];
        assign sy    = bus.spr_y[10*i +: 10];
        assign sz    = bus.spr_size[6*i +: 6];
        assign x_end = {1'b0, sx} + {6'b0, sz};
        assign y_end = {1'b0, sy} + {5'b0, sz};
        assign hit_c[i] = bus.spr_en[i] & (sz != 6'd0)
                        & (bus.draw_x >= sx) & ({1'b0, bus.draw_x} < x_end)
                        & (bus.draw_y >= sy) & ({1'b0, bus.draw_y} < y_end);
    end

    assign border_c = (bus.draw_x < X_LO) | (bus.draw_x >= X_HI)
                    | (bus.draw_y < Y_LO) | (bus.draw_y >= Y_HI);

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_hit    <= '0;
            s1_border <= 1'b0;
            s1_rgb    <= '0;
        end else begin
            s1_valid  <= bus.pix_valid_in;
            s1_hit    <= hit_c;
            s1_border <= border_c;
            s1_rgb    <= bus.spr_rgb;
        end
    end

    // Walk from lowest priority upward so channel 0 wins; sprites cover the border.
    always_comb begin
        pix_c = s1_border ? BORDER_RGB : BG_RGB;
        for (int i = N_SPR - 1; i >= 0; i--) begin
            if (s1_hit[i]) pix_c = s1_rgb[12*i +: 12];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            pix_q   <= '0;
        end else begin
            valid_q <= s1_valid;
            pix_q   <= s1_valid ? pix_c : 12'h000;
        end
    end

    // Two or more bits set exactly when clearing the lowest set bit leaves something.
    assign multi_hit = |(s1_hit & (s1_hit - ONE));
    assign contrib   = (s1_valid && multi_hit) ? s1_hit : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc           <= '0;
            coll_status_q <= '0;
            coll_valid_q  <= 1'b0;
        end else begin
            coll_valid_q <= bus.frame_start;
            if (bus.frame_start) begin
                coll_status_q <= acc;
                acc           <= contrib;
            end else begin
                acc <= acc | contrib;
            end
        end
    end

    assign bus.pix_valid_out = valid_q;
    assign bus.r             = pix_q[11:8];
    assign bus.g             = pix_q[7:4];
    assign bus.b             = pix_q[3:0];
    assign bus.coll_status   = coll_status_q;
    assign bus.coll_valid    = coll_valid_q;
endmodule
